// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
// Module  : spi_pkg
// Brief   : Shared defaults and FSM encoding for the SPI joystick responder.
// Revision: 1.0 - initial release
// ============================================================================
package spi_pkg;

    localparam int c_frame_bits  = 40;
    localparam int c_sync_stages = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } spi_state_t;

endpackage
`default_nettype wire

// File: rtl/spi_sync_edge.sv
`default_nettype none
// ============================================================================
// Module  : spi_sync_edge
// Brief   : Multi-stage input synchronizer with registered rise/fall detect.
// Revision: 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_rst_val,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= {SYNC_STAGES{i_rst_val}};
            r_prev <= i_rst_val;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], i_async};
            r_prev <= r_sync[SYNC_STAGES-1];
        end
    end

    assign o_sync = r_sync[SYNC_STAGES-1];
    assign o_rise =  r_sync[SYNC_STAGES-1] & ~r_prev;
    assign o_fall = ~r_sync[SYNC_STAGES-1] &  r_prev;

endmodule
`default_nettype wire

// File: rtl/spi_joystick_responder.sv
`default_nettype none
// ============================================================================
// Module  : spi_joystick_responder
// Brief   : Oversampled SPI mode-0 slave emulating the joystick end of a link.
// Revision: 1.0 - initial release
// ============================================================================
module spi_joystick_responder
    import spi_pkg::*;
#(
    parameter int FRAME_BITS  = c_frame_bits,
    parameter int SYNC_STAGES = c_sync_stages
) (
    input  logic                  clk50M,
    input  logic                  rst_n,
    input  logic                  cs,
    input  logic                  sck,
    input  logic                  mosi,
    output logic                  miso,
    output logic                  miso_oe,
    input  logic [FRAME_BITS-1:0] tx_bytes,
    output logic [FRAME_BITS-1:0] rx_bytes,
    output logic                  rx_valid,
    output logic                  frame_err,
    output logic                  busy
);

    localparam int                 c_cnt_w = $clog2(FRAME_BITS + 1);
    localparam logic [c_cnt_w-1:0] c_full  = c_cnt_w'(FRAME_BITS);

    logic w_cs_sync, w_cs_rise, w_cs_fall;
    logic w_sck_sync, w_sck_rise, w_sck_fall;
    logic w_mosi_sync, w_mosi_rise, w_mosi_fall;
    logic w_unused;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_cs_sync (
        .clk(clk50M), .rst_n(rst_n), .i_rst_val(1'b1), .i_async(cs),
        .o_sync(w_cs_sync), .o_rise(w_cs_rise), .o_fall(w_cs_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sck_sync (
        .clk(clk50M), .rst_n(rst_n), .i_rst_val(1'b0), .i_async(sck),
        .o_sync(w_sck_sync), .o_rise(w_sck_rise), .o_fall(w_sck_fall)
    );

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_mosi_sync (
        .clk(clk50M), .rst_n(rst_n), .i_rst_val(1'b0), .i_async(mosi),
        .o_sync(w_mosi_sync), .o_rise(w_mosi_rise), .o_fall(w_mosi_fall)
    );

    spi_state_t          r_state;
    logic [c_cnt_w-1:0]  r_bit_cnt;
    logic [FRAME_BITS-1:0] r_tx_shift;
    logic [FRAME_BITS-1:0] r_rx_shift;
    logic [FRAME_BITS-1:0] r_rx_bytes;
    logic                r_miso, r_miso_oe, r_rx_valid, r_frame_err, r_busy;
    logic                r_fall_pend;

    // The MSB of the tx shifter is already on r_miso when loaded, so it is never read back.
    assign w_unused = ^{w_cs_sync, w_sck_sync, w_mosi_rise, w_mosi_fall,
                        r_tx_shift[FRAME_BITS-1]};

    always_ff @(posedge clk50M or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_tx_shift  <= '0;
            r_rx_shift  <= '0;
            r_rx_bytes  <= '0;
            r_miso      <= 1'b0;
            r_miso_oe   <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            r_busy      <= 1'b0;
            r_fall_pend <= 1'b0;
        end else begin
            r_rx_valid  <= 1'b0;
            r_frame_err <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    r_fall_pend <= 1'b0;
                    if (w_cs_fall || r_fall_pend) begin
                        r_tx_shift <= tx_bytes;
                        r_miso     <= tx_bytes[FRAME_BITS-1];
                        r_miso_oe  <= 1'b1;
                        r_busy     <= 1'b1;
                        r_bit_cnt  <= '0;
                        r_state    <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    // cs rise takes priority over any coincident sck edge.
                    if (w_cs_rise) begin
                        r_state <= ST_DONE;
                    end else if (w_sck_rise) begin
                        if (r_bit_cnt != c_full) begin
                            r_rx_shift <= {r_rx_shift[FRAME_BITS-2:0], w_mosi_sync};
                            r_bit_cnt  <= r_bit_cnt + 1'b1;
                        end
                    end else if (w_sck_fall) begin
                        r_tx_shift <= {r_tx_shift[FRAME_BITS-2:0], 1'b0};
                        r_miso     <= r_tx_shift[FRAME_BITS-2];
                    end
                end
                ST_DONE: begin
                    r_busy    <= 1'b0;
                    r_miso_oe <= 1'b0;
                    r_miso    <= 1'b0;
                    if (r_bit_cnt == c_full) begin
                        r_rx_bytes <= r_rx_shift;
                        r_rx_valid <= 1'b1;
                    end else begin
                        r_frame_err <= 1'b1;
                    end
                    // A new frame starting here would otherwise be lost before IDLE sees it.
                    if (w_cs_fall) begin
                        r_fall_pend <= 1'b1;
                    end
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign miso      = r_miso;
    assign miso_oe   = r_miso_oe;
    assign rx_bytes  = r_rx_bytes;
    assign rx_valid  = r_rx_valid;
    assign frame_err = r_frame_err;
    assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_spi_joystick_responder.sv
`default_nettype none
// ============================================================================
// Module  : tb_spi_joystick_responder
// Brief   : Self-checking bench driving SPI frames against a behavioural model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_spi_joystick_responder;

    localparam int FB = 40;
    localparam int SS = 2;

    logic          clk50M   = 1'b0;
    logic          rst_n    = 1'b0;
    logic          cs       = 1'b1;
    logic          sck      = 1'b0;
    logic          mosi     = 1'b0;
    logic [FB-1:0] tx_bytes = '0;
    logic          miso, miso_oe, rx_valid, frame_err, busy;
    logic [FB-1:0] rx_bytes;

    int            n_cmp   = 0;
    int            n_bad   = 0;
    int            n_valid = 0;
    int            n_err   = 0;
    logic [FB-1:0] exp_rx  = '0;

    spi_joystick_responder #(.FRAME_BITS(FB), .SYNC_STAGES(SS)) u_dut (
        .clk50M(clk50M), .rst_n(rst_n), .cs(cs), .sck(sck), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .tx_bytes(tx_bytes),
        .rx_bytes(rx_bytes), .rx_valid(rx_valid), .frame_err(frame_err),
        .busy(busy)
    );

    always #10 clk50M = ~clk50M;

    always @(negedge clk50M) begin
        if (rst_n) begin
            if (rx_valid)  n_valid++;
            if (frame_err) n_err++;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one master frame of nbits; mbits holds the bits, first-sent in bit nbits-1.
    task automatic run_frame(input string tag, input int nbits, input logic [63:0] mbits,
                             input int half, input int abort_at, input int chg_at,
                             input logic [FB-1:0] new_tx);
        logic [63:0]   cap;
        logic [63:0]   exp_miso;
        logic [FB-1:0] tx0;
        int            v0, e0, lat;
        bit            oe_bad, busy_bad;
        cap = '0; tx0 = tx_bytes; v0 = n_valid; e0 = n_err; lat = -1;
        oe_bad = 1'b0; busy_bad = 1'b0;

        @(negedge clk50M);
        cs   = 1'b0;
        mosi = mbits[nbits-1];
        repeat (half) @(negedge clk50M);
        for (int i = 0; i < nbits; i++) begin
            if (i == abort_at) begin
                rst_n = 1'b0; cs = 1'b1; sck = 1'b0; mosi = 1'b0;
                repeat (3) @(negedge clk50M);
                check({tag, " rst miso"},      64'(miso),      64'd0);
                check({tag, " rst miso_oe"},   64'(miso_oe),   64'd0);
                check({tag, " rst busy"},      64'(busy),      64'd0);
                check({tag, " rst rx_bytes"},  64'(rx_bytes),  64'd0);
                check({tag, " rst rx_valid"},  64'(rx_valid),  64'd0);
                check({tag, " rst frame_err"}, 64'(frame_err), 64'd0);
                rst_n  = 1'b1;
                exp_rx = '0;
                repeat (20) @(negedge clk50M);
                #1;
                check({tag, " rst no pulses"}, 64'(n_valid + n_err), 64'(v0 + e0));
                check({tag, " rst idle oe"},   64'(miso_oe),          64'd0);
                return;
            end
            if (i == chg_at) tx_bytes = new_tx;
            cap = {cap[62:0], miso};
            if (!miso_oe) oe_bad = 1'b1;
            if (!busy)    busy_bad = 1'b1;
            sck = 1'b1;
            repeat (half) @(negedge clk50M);
            sck  = 1'b0;
            mosi = (i + 1 < nbits) ? mbits[nbits-2-i] : 1'b0;
            repeat (half) @(negedge clk50M);
        end
        cs = 1'b1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk50M);
            if (rx_valid || frame_err) begin
                lat = k;
                break;
            end
        end
        #1;

        // Reference: the first FB bits sent form the command; miso carries tx MSB first then zeros.
        if (nbits >= FB) exp_rx = FB'(mbits >> (nbits - FB));
        exp_miso = (nbits <= FB) ? (64'(tx0) >> (FB - nbits)) : (64'(tx0) << (nbits - FB));

        check({tag, " miso stream"}, cap, exp_miso);
        check({tag, " oe in frame"}, 64'(oe_bad), 64'd0);
        check({tag, " busy in frame"}, 64'(busy_bad), 64'd0);
        check({tag, " latency"}, 64'(lat), 64'(SS + 2));
        check({tag, " rx_valid cnt"}, 64'(n_valid - v0), (nbits >= FB) ? 64'd1 : 64'd0);
        check({tag, " frame_err cnt"}, 64'(n_err - e0), (nbits >= FB) ? 64'd0 : 64'd1);
        check({tag, " rx_bytes"}, 64'(rx_bytes), 64'(exp_rx));
        @(negedge clk50M);
        check({tag, " end oe"}, 64'(miso_oe), 64'd0);
        check({tag, " end busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        logic [FB-1:0] t_new;
        int            v0, e0;
        bit            oe_seen;
        repeat (3) @(negedge clk50M);
        check("reset miso",      64'(miso),      64'd0);
        check("reset miso_oe",   64'(miso_oe),   64'd0);
        check("reset rx_bytes",  64'(rx_bytes),  64'd0);
        check("reset rx_valid",  64'(rx_valid),  64'd0);
        check("reset frame_err", 64'(frame_err), 64'd0);
        check("reset busy",      64'(busy),      64'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk50M);

        tx_bytes = 40'h12_3456_789A;
        run_frame("normal", 40, 64'h83_0000_0000, 25, -1, -1, '0);
        run_frame("short", 17, 64'(17'h1_5A5A), 6, -1, -1, '0);
        tx_bytes = 40'hC3_5AA5_0FF0;
        run_frame("after short", 40, 64'h3C_DEAD_BEEF, 5, -1, -1, '0);
        tx_bytes = 40'h0F_1E2D_3C4B;
        run_frame("long", 45, {19'd0, 40'hA5_A5A5_A5A5, 5'b11111}, 5, -1, -1, '0);
        run_frame("abort", 40, 64'h11_2233_4455, 5, 20, -1, '0);
        tx_bytes = 40'h55_AA55_AA55;
        run_frame("post reset", 40, 64'hFF_00FF_00FF, 5, -1, -1, '0);

        t_new = 40'h96_8778_6951;
        tx_bytes = 40'h01_2345_6789;
        run_frame("b2b f1", 40, 64'h24_6813_579B, 4, -1, 20, t_new);
        run_frame("b2b f2", 40, 64'hE7_1C38_E71C, 4, -1, -1, '0);

        v0 = n_valid; e0 = n_err; oe_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            sck = 1'b1; repeat (5) @(negedge clk50M);
            if (miso_oe) oe_seen = 1'b1;
            sck = 1'b0; repeat (5) @(negedge clk50M);
            if (miso_oe) oe_seen = 1'b1;
        end
        #1;
        check("idle oe",       64'(oe_seen), 64'd0);
        check("idle pulses",   64'(n_valid + n_err), 64'(v0 + e0));
        check("idle rx_bytes", 64'(rx_bytes), 64'(exp_rx));

        for (int r = 0; r < 8; r++) begin
            int          nb;
            int          sel;
            logic [63:0] mb;
            sel = int'($urandom_range(0, 2));
            nb  = (sel == 0) ? FB : (sel == 1) ? int'($urandom_range(1, FB - 1))
                                               : int'($urandom_range(FB + 1, 48));
            mb  = {32'($urandom), 32'($urandom)};
            tx_bytes = {8'($urandom), 32'($urandom)};
            run_frame($sformatf("rand%0d n%0d", r, nb), nb, mb,
                      int'($urandom_range(4, 12)), -1, -1, '0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL timeout: got no end expected finish");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire
